logic_op_sequencer: RTL

Control stage wrapped around the 8-bit AND/OR logic selector. It accepts one instruction at a time over a valid/ready handshake and holds an internal register file. It drives the selector's operand and select inputs from registered state, then captures the selector's result and writes it back. It sits directly upstream of the selector, because it feeds A/B/S, and directly downstream of it, because it consumes Z.

---
 rtl/logic_op_sequencer_pkg.sv | 28 ++
 rtl/logic_op_sequencer_if.sv | 39 +++
 rtl/logic_op_sequencer_reg_file.sv | 43 ++++
 rtl/logic_op_sequencer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/logic_op_sequencer_pkg.sv
// Shared definitions for the logic op sequencer: opcodes, FSM states,
// selector encodings and default sizing.
package logic_op_sequencer_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NREGS = 8;
    localparam int DEF_AW    = 3;

    localparam logic [1:0] OP_LOADI = 2'b00;
    localparam logic [1:0] OP_AND   = 2'b01;
    localparam logic [1:0] OP_OR    = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic SEL_AND = 1'b0;
    localparam logic SEL_OR  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2
    } state_t;

    // Maps a logic opcode onto the selector's S input.
    function automatic logic op_to_sel(input logic [1:0] op);
        return (op == OP_OR) ? SEL_OR : SEL_AND;
    endfunction

endpackage

// File: rtl/logic_op_sequencer_if.sv
// Bus between the sequencer and its environment: instruction handshake,
// selector operand/result wires, retire status and debug read port.
//   slave  : sequencer side (accepts instructions, drives OPA/OPB/SEL)
//   master : environment side (issues instructions, supplies SEL_RESULT)
interface logic_op_sequencer_if
    import logic_op_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW
) ();

    logic             INSTR_VALID;
    logic             INSTR_READY;
    logic [1:0]       OPCODE;
    logic [AW-1:0]    DEST;
    logic [AW-1:0]    SRC1;
    logic [AW-1:0]    SRC2;
    logic [WIDTH-1:0] IMM;
    logic [WIDTH-1:0] OPA;
    logic [WIDTH-1:0] OPB;
    logic             SEL;
    logic [WIDTH-1:0] SEL_RESULT;
    logic             DONE;
    logic [WIDTH-1:0] RESULT_OUT;
    logic             ERR;
    logic [AW-1:0]    DBG_ADDR;
    logic [WIDTH-1:0] DBG_DATA;

    modport slave (
        input  INSTR_VALID, OPCODE, DEST, SRC1, SRC2, IMM, SEL_RESULT, DBG_ADDR,
        output INSTR_READY, OPA, OPB, SEL, DONE, RESULT_OUT, ERR, DBG_DATA
    );

    modport master (
        output INSTR_VALID, OPCODE, DEST, SRC1, SRC2, IMM, SEL_RESULT, DBG_ADDR,
        input  INSTR_READY, OPA, OPB, SEL, DONE, RESULT_OUT, ERR, DBG_DATA
    );

endinterface

// File: rtl/logic_op_sequencer_reg_file.sv
// logic_reg_file: NREGS x WIDTH register file with two combinational read
// ports, one combinational debug read port, one synchronous write port and
// asynchronous active-low clear.
//   i_clk, i_rst_n             clock / async clear
//   i_we, i_waddr, i_wdata     write port
//   i_raddr1/2 -> o_rdata1/2   operand read ports
//   i_dbg_addr -> o_dbg_data   debug read port
module logic_reg_file #(
    parameter int WIDTH = 8,
    parameter int NREGS = 8,
    parameter int AW    = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr1,
    input  logic [AW-1:0]    i_raddr2,
    input  logic [AW-1:0]    i_dbg_addr,
    output logic [WIDTH-1:0] o_rdata1,
    output logic [WIDTH-1:0] o_rdata2,
    output logic [WIDTH-1:0] o_dbg_data
);

    logic [WIDTH-1:0] r_mem [NREGS];

    // Storage: cleared asynchronously, written on the rising edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1   = r_mem[i_raddr1];
    assign o_rdata2   = r_mem[i_raddr2];
    assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/logic_op_sequencer.sv
// logic_op_sequencer: accepts one instruction at a time, feeds the external
// AND/OR selector from registered operands and writes its result back.
//   CLK, RESET_N : clock and asynchronous active-low reset
//   bus (slave)  : instruction handshake, OPA/OPB/SEL to the selector,
//                  SEL_RESULT from it, DONE/ERR/RESULT_OUT status,
//                  DBG_ADDR/DBG_DATA debug read.
module logic_op_sequencer
    import logic_op_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREGS = DEF_NREGS,
    parameter int AW    = DEF_AW
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    logic_op_sequencer_if.slave   bus
);

    state_t           r_state;
    state_t           w_next_state;
    logic [1:0]       r_opcode;
    logic [AW-1:0]    r_dest;
    logic [AW-1:0]    r_src1;
    logic [AW-1:0]    r_src2;
    logic [WIDTH-1:0] r_imm;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic             r_sel;
    logic [WIDTH-1:0] r_result;
    logic             r_done;
    logic             r_err;

    logic             w_accept;
    logic             w_rf_we;
    logic [WIDTH-1:0] w_rf_wdata;
    logic             w_load_ops;
    logic             w_done;
    logic             w_err;
    logic [WIDTH-1:0] w_rd1;
    logic [WIDTH-1:0] w_rd2;

    assign w_accept = (r_state == IDLE) && bus.INSTR_VALID;

    logic_reg_file #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_rf (
        .i_clk      (CLK),
        .i_rst_n    (RESET_N),
        .i_we       (w_rf_we),
        .i_waddr    (r_dest),
        .i_wdata    (w_rf_wdata),
        .i_raddr1   (r_src1),
        .i_raddr2   (r_src2),
        .i_dbg_addr (bus.DBG_ADDR),
        .o_rdata1   (w_rd1),
        .o_rdata2   (w_rd2),
        .o_dbg_data (bus.DBG_DATA)
    );

    // FSM state register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-state control strobes.
    always_comb begin
        w_next_state = r_state;
        w_rf_we      = 1'b0;
        w_rf_wdata   = {WIDTH{1'b0}};
        w_load_ops   = 1'b0;
        w_done       = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.INSTR_VALID) begin
                    w_next_state = DECODE;
                end else begin
                    w_next_state = IDLE;
                end
            end
            DECODE: begin
                case (r_opcode)
                    OP_LOADI: begin
                        w_rf_we      = 1'b1;
                        w_rf_wdata   = r_imm;
                        w_done       = 1'b1;
                        w_next_state = IDLE;
                    end
                    OP_AND, OP_OR: begin
                        w_load_ops   = 1'b1;
                        w_next_state = EXEC;
                    end
                    OP_RSVD: begin
                        w_done       = 1'b1;
                        w_err        = 1'b1;
                        w_next_state = IDLE;
                    end
                    default: begin
                        w_next_state = IDLE;
                    end
                endcase
            end
            EXEC: begin
                // Operands have been stable for a full cycle, so Z is settled.
                w_rf_we      = 1'b1;
                w_rf_wdata   = bus.SEL_RESULT;
                w_done       = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Instruction latch, selector operands and retire status.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_opcode <= OP_LOADI;
            r_dest   <= {AW{1'b0}};
            r_src1   <= {AW{1'b0}};
            r_src2   <= {AW{1'b0}};
            r_imm    <= {WIDTH{1'b0}};
            r_opa    <= {WIDTH{1'b0}};
            r_opb    <= {WIDTH{1'b0}};
            r_sel    <= SEL_AND;
            r_result <= {WIDTH{1'b0}};
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_opcode <= bus.OPCODE;
                r_dest   <= bus.DEST;
                r_src1   <= bus.SRC1;
                r_src2   <= bus.SRC2;
                r_imm    <= bus.IMM;
            end
            // Sources read here, before any write-back, so DEST==SRC sees the old value.
            if (w_load_ops) begin
                r_opa <= w_rd1;
                r_opb <= w_rd2;
                r_sel <= op_to_sel(r_opcode);
            end
            if (w_rf_we) begin
                r_result <= w_rf_wdata;
            end
            r_done <= w_done;
            r_err  <= w_err;
        end
    end

    assign bus.INSTR_READY = (r_state == IDLE);
    assign bus.OPA         = r_opa;
    assign bus.OPB         = r_opb;
    assign bus.SEL         = r_sel;
    assign bus.RESULT_OUT  = r_result;
    assign bus.DONE        = r_done;
    assign bus.ERR         = r_err;

endmodule
